// File: rtl/layer_sequencer.sv
// Layer sequencer: latches one input vector, broadcasts it to all neurons, gathers each
// neuron's first result and hands the layer result downstream. Watchdog: LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 6,
  parameter int N_NEU      = 3,
  parameter int TIMEOUT    = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [N_IN*DATA_WIDTH-1:0]    in_data,
  output logic                          in_ready,
  output logic                          neu_en,
  output logic                          neu_run,
  output logic [N_IN*DATA_WIDTH-1:0]    neu_x,
  input  logic [N_NEU-1:0]              neu_ready,
  input  logic [N_NEU*(DATA_WIDTH+6)-1:0] neu_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEU*(DATA_WIDTH+6)-1:0] out_data,
  output logic                          busy,
  output logic                          err,
  input  logic                          clr_err
);

  localparam int YW = DATA_WIDTH + 6;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, ERROR} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_NEU-1:0] seen;
  logic [N_NEU-1:0] hit;
  logic             all_seen;
  logic             timeout_hit;

`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt     = cnt + 1'b1;
  assign timeout_hit = (cnt_nxt == CW'(TIMEOUT));
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // Only neurons not yet seen in this pass are captured; completion counts this cycle's hits.
  assign hit      = (state == WAIT) ? (neu_ready & ~seen) : '0;
  assign all_seen = &(seen | neu_ready);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (all_seen)         state_nxt = OUTPUT;
        else if (timeout_hit) state_nxt = ERROR;
      end
      OUTPUT:  if (out_ready) state_nxt = IDLE;
`ifdef LAYER_SEQ_WATCHDOG_EN
      ERROR:   if (clr_err) state_nxt = IDLE;
`else
      ERROR:   state_nxt = ERROR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: asynchronous reset in the sensitivity list; all state uses non-blocking updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      neu_x     <= '0;
      out_data  <= '0;
      seen      <= '0;
      in_ready  <= 1'b1;
      neu_en    <= 1'b0;
      neu_run   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef LAYER_SEQ_WATCHDOG_EN
      cnt       <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      neu_en    <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      neu_run   <= (state_nxt == ISSUE) || (state_nxt == WAIT);
      out_valid <= (state_nxt == OUTPUT);
      busy      <= (state_nxt != IDLE);

      if (state == IDLE && in_valid) begin
        neu_x <= in_data;
        seen  <= '0;
      end else begin
        seen  <= seen | hit;
      end

      for (int i = 0; i < N_NEU; i++) begin
        if (hit[i]) out_data[i*YW +: YW] <= neu_y[i*YW +: YW];
      end

`ifdef LAYER_SEQ_WATCHDOG_EN
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt_nxt;
      err <= (state_nxt == ERROR);
`endif
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed passes plus randomized traffic
// compared every cycle against a pass-level reference model.
module tb_layer_sequencer;

  localparam int DW = 8;
  localparam int NI = 6;
  localparam int NN = 3;
  localparam int TO = 31;
  localparam int XW = NI * DW;
  localparam int YW = DW + 6;
  localparam int OW = NN * YW;
`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_err   = 1'b0;
  logic [XW-1:0] in_data   = '0;
  logic [NN-1:0] neu_ready = '0;
  logic [OW-1:0] neu_y     = '0;
  logic          in_ready, neu_en, neu_run, out_valid, busy, err;
  logic [XW-1:0] neu_x;
  logic [OW-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  layer_sequencer #(.DATA_WIDTH(DW), .N_IN(NI), .N_NEU(NN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .neu_en(neu_en), .neu_run(neu_run), .neu_x(neu_x), .neu_ready(neu_ready), .neu_y(neu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .err(err), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pass is in exactly one of its phases; none set means idle.
  bit            m_issue, m_wait, m_hold, m_fault;
  int            m_waited;
  bit            m_seen [NN];
  logic [YW-1:0] m_res  [NN];
  logic [XW-1:0] m_x;

  function automatic bit m_idle();
    return !(m_issue || m_wait || m_hold || m_fault);
  endfunction

  task automatic model_reset();
    m_issue = 0; m_wait = 0; m_hold = 0; m_fault = 0; m_waited = 0; m_x = '0;
    for (int i = 0; i < NN; i++) begin
      m_seen[i] = 0;
      m_res[i]  = '0;
    end
  endtask

  task automatic model_step();
    int n;
    if (m_idle()) begin
      if (in_valid) begin
        m_x = in_data;
        for (int i = 0; i < NN; i++) m_seen[i] = 0;
        m_issue = 1;
      end
    end else if (m_issue) begin
      m_issue = 0; m_wait = 1; m_waited = 0;
    end else if (m_wait) begin
      n = 0;
      for (int i = 0; i < NN; i++) begin
        if (neu_ready[i] && !m_seen[i]) begin
          m_res[i]  = neu_y[i*YW +: YW];
          m_seen[i] = 1;
        end
        n += int'(m_seen[i]);
      end
      m_waited++;
      if (n == NN) begin
        m_wait = 0; m_hold = 1;
      end else if (WDOG && m_waited == TO) begin
        m_wait = 0; m_fault = 1;
      end
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (m_fault) begin
      if (WDOG && clr_err) m_fault = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic compare_all();
    logic [OW-1:0] eo;
    for (int i = 0; i < NN; i++) eo[i*YW +: YW] = m_res[i];
    check("in_ready",  64'(in_ready),  64'(m_idle()));
    check("neu_en",    64'(neu_en),    64'(m_issue || m_wait));
    check("neu_run",   64'(neu_run),   64'(m_issue || m_wait));
    check("out_valid", 64'(out_valid), 64'(m_hold));
    check("busy",      64'(busy),      64'(!m_idle()));
    check("err",       64'(err),       64'(m_fault));
    check("neu_x",     64'(neu_x),     64'(m_x));
    check("out_data",  64'(out_data),  64'(eo));
  endtask

  always @(negedge clk) if (chk_on) compare_all();

  function automatic logic [YW-1:0] rand_y();
    logic [31:0] r;
    r = $urandom;
    return r[YW-1:0];
  endfunction

  function automatic logic [XW-1:0] rand_x();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[XW-1:0];
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (!m_idle() && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 64'(m_idle()), 64'd1);
  endtask

  task automatic drain();
    int k;
    neu_ready = '1; out_ready = 1; in_valid = 0; clr_err = 1;
    k = 0;
    while (!m_idle() && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drain_idle", 64'(m_idle()), 64'd1);
    neu_ready = '0; out_ready = 0; clr_err = 0;
  endtask

  // One pass: neuron i first ready in WAIT cycle r[i] (0-based) presenting tag t[i]; the
  // result is then held for bp cycles with a new vector nx waiting upstream.
  task automatic do_pass(input logic [XW-1:0] x, input int r0, input int r1, input int r2,
                         input logic [YW-1:0] t0, input logic [YW-1:0] t1,
                         input logic [YW-1:0] t2, input int bp, input logic [XW-1:0] nx);
    int            ra [NN];
    logic [YW-1:0] tg [NN];
    logic [OW-1:0] eo;
    int            j, mx;
    bit            got;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    tg[0] = t0; tg[1] = t1; tg[2] = t2;
    eo = {t2, t1, t0};
    mx = (r0 > r1) ? r0 : r1;
    mx = (mx > r2) ? mx : r2;
    neu_ready = '0; out_ready = 0;
    wait_idle();
    in_valid = 1; in_data = x;
    @(negedge clk);
    in_valid = 0;
    j = 1; got = 0;
    while (!got && j < 200) begin
      for (int i = 0; i < NN; i++) begin
        neu_ready[i] = (j - 2 >= ra[i]);
        neu_y[i*YW +: YW] = (j - 2 == ra[i]) ? tg[i] : rand_y();
      end
      @(negedge clk);
      j++;
      got = out_valid;
    end
    neu_ready = '0;
    check("pass_latency", 64'(j + 1), 64'(mx + 4));
    check("pass_out",     64'(out_data), 64'(eo));
    check("pass_x",       64'(neu_x), 64'(x));
    check("pass_err",     64'(err), 64'd0);
    for (int k = 0; k < bp; k++) begin
      in_valid = 1; in_data = nx;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_hold", 64'(out_data), 64'(eo));
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready",  64'(in_ready),  64'd1);
    if (bp > 0) begin
      @(negedge clk);
      in_valid = 0;
      check("bp_accept_busy", 64'(busy), 64'd1);
      check("bp_accept_x",    64'(neu_x), 64'(nx));
      drain();
    end
  endtask

  initial begin
    model_reset();
    #1 chk_on = 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    rst = 0;

    do_pass(48'h060504030201, 5, 5, 5, 14'h10, 14'h20, 14'h30, 0, '0);
    do_pass(rand_x(), 2, 4, 7, 14'h0155, 14'h2aaa, 14'h3c3c, 0, '0);
    do_pass(rand_x(), 0, 0, 0, rand_y(), rand_y(), rand_y(), 10, rand_x());

    // Reset in the middle of a WAIT phase.
    wait_idle();
    in_valid = 1; in_data = rand_x();
    @(negedge clk);
    in_valid = 0; neu_ready = 3'b001; neu_y = {rand_y(), rand_y(), rand_y()};
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_neu_run",  64'(neu_run),  64'd0);
    check("mid_rst_neu_en",   64'(neu_en),   64'd0);
    check("mid_rst_busy",     64'(busy),     64'd0);
    check("mid_rst_neu_x",    64'(neu_x),    64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    compare_all();
    @(negedge clk);
    rst = 0; neu_ready = '0;
    do_pass(rand_x(), 1, 3, 0, rand_y(), rand_y(), rand_y(), 0, '0);

`ifdef LAYER_SEQ_WATCHDOG_EN
    begin
      int j;
      wait_idle();
      in_valid = 1; in_data = rand_x();
      @(negedge clk);
      in_valid = 0; neu_ready = 3'b011;
      j = 1;
      while (!err && j < 100) begin
        @(negedge clk);
        j++;
      end
      check("wdog_wait_cycles", 64'(j - 2), 64'(TO));
      check("wdog_err",       64'(err),       64'd1);
      check("wdog_neu_run",   64'(neu_run),   64'd0);
      check("wdog_neu_en",    64'(neu_en),    64'd0);
      check("wdog_out_valid", 64'(out_valid), 64'd0);
      check("wdog_in_ready",  64'(in_ready),  64'd0);
      neu_ready = '0; clr_err = 1;
      @(negedge clk);
      clr_err = 0;
      check("clr_err_err",      64'(err),      64'd0);
      check("clr_err_in_ready", 64'(in_ready), 64'd1);
    end
    do_pass(rand_x(), 3, 30, 10, rand_y(), rand_y(), rand_y(), 0, '0);
`else
    do_pass(rand_x(), 100, 100, 100, rand_y(), rand_y(), rand_y(), 0, '0);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(1) == 0);
      in_data   = rand_x();
      for (int i = 0; i < NN; i++) begin
        neu_ready[i] = ($urandom_range(3) == 0);
        neu_y[i*YW +: YW] = rand_y();
      end
      out_ready = ($urandom_range(1) == 0);
      clr_err   = ($urandom_range(9) == 0);
      if ($urandom_range(399) == 0) begin
        #2 rst = 1;
        @(negedge clk);
        rst = 0;
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one neuron input element.
REQ-002 Parameter N_IN, default 6, number of inputs per neuron.
REQ-003 Parameter N_NEU, default 3, number of neurons in the layer.
REQ-004 Parameter TIMEOUT, default 31, watchdog limit in cycles for WAIT.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream input vector valid.
REQ-008 in_data  input  N_IN*DATA_WIDTH  packed input vector, element 0 in the LSBs.
REQ-009 in_ready  output  1  sequencer accepts in_data.
REQ-010 neu_en  output  1  enable broadcast to all neurons.
REQ-011 neu_run  output  1  run request broadcast to all neurons.
REQ-012 neu_x  output  N_IN*DATA_WIDTH  registered operand vector driven to all neurons.
REQ-013 neu_ready  input  N_NEU  per-neuron Ready.
REQ-014 neu_y  input  N_NEU*(DATA_WIDTH+6)  packed per-neuron results.
REQ-015 out_valid  output  1  layer result valid.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_data  output  N_NEU*(DATA_WIDTH+6)  captured layer result, neuron 0 in the LSBs.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 err  output  1  sticky watchdog error.
REQ-020 clr_err  input  1  clears the error and returns to IDLE.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, OUTPUT and ERROR.
REQ-022 IDLE: in_ready=1. When in_valid=1, the block SHALL capture in_data into neu_x, clear the seen mask and go to ISSUE.
REQ-023 ISSUE lasts one cycle with neu_en=1 and neu_run=1, then the FSM goes to WAIT with the watchdog counter at 0.
REQ-024 WAIT: neu_en=1 and neu_run=1. For each neuron i with neu_ready[i]=1 and seen[i]=0, the block SHALL capture neu_y slice i into out_data slice i and set seen[i] in that cycle.
REQ-025 A neuron already marked seen SHALL NOT be recaptured in the same pass.
REQ-026 When every bit of seen, including bits set in the current cycle, is 1, the FSM SHALL go to OUTPUT on the next edge, and neu_run and neu_en SHALL be 0 from that edge onward.
REQ-027 OUTPUT: out_valid=1, and out_data SHALL be held stable until out_ready=1. On that handshake the FSM SHALL go to IDLE, with out_valid=0 from the next cycle.
REQ-028 in_ready SHALL be 1 only in IDLE; input presented in any other state SHALL be held off, not dropped.
REQ-029 neu_x SHALL change only on an IDLE capture and SHALL stay stable through ISSUE, WAIT and OUTPUT.
REQ-030 Minimum latency SHALL be 4 cycles: from in_valid accepted to out_valid=1 when all neu_ready bits rise together in the first WAIT cycle.
REQ-031 The watchdog counter SHALL increment once per WAIT cycle; the counter width SHALL be ceil(log2(TIMEOUT+1)).
REQ-032 A counter value of TIMEOUT with seen incomplete SHALL force ERROR.
REQ-033 ERROR: err=1, neu_run=0, neu_en=0, out_valid=0, in_ready=0.
REQ-034 clr_err=1 in ERROR SHALL clear err and go to IDLE next cycle; clr_err SHALL be ignored in all other states.
REQ-035 neu_ready completing in the same cycle as the counter reaching TIMEOUT SHALL give OUTPUT, not ERROR.

Reset
REQ-036 rst SHALL force state IDLE, neu_x=0, out_data=0, seen=0, counter=0, err=0, out_valid=0, neu_run=0, neu_en=0, busy=0, in_ready=1, regardless of any pass in progress.
REQ-037 A result pending in OUTPUT when rst is asserted SHALL be discarded.

Configuration
REQ-038 Macro LAYER_SEQ_WATCHDOG_EN, when defined, SHALL compile in the watchdog counter, the ERROR state and clr_err handling.
REQ-039 Without LAYER_SEQ_WATCHDOG_EN, WAIT SHALL wait indefinitely, err SHALL be tied 0, clr_err SHALL be unused and ERROR SHALL be unreachable.

Verification
REQ-040 Single pass: in_data elements 1..6, all neu_ready rise together at WAIT cycle 5 with y={0x10,0x20,0x30} -> out_data={0x10,0x20,0x30}, out_valid 9 cycles after acceptance.
REQ-041 Staggered ready: neurons ready at WAIT cycles 2, 4 and 7, each with y changing after its ready -> each slice holds the value present at its own first ready; OUTPUT entered after cycle 7.
REQ-042 Backpressure: out_ready low for 10 cycles while in_valid=1 -> out_data stable, in_ready=0 throughout; input accepted one cycle after the handshake.
REQ-043 Watchdog (macro on, TIMEOUT=31): neuron 2 never ready -> err=1 after 31 WAIT cycles with run and en low; clr_err -> IDLE and err=0.
REQ-044 rst asserted mid-WAIT -> all outputs at reset values immediately; the next pass completes correctly.
REQ-045 Macro off: neu_ready withheld for 100 cycles -> no error, result delivered once ready.
